// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter and sequencer for a bank of
// WORDS byte-writable 32-bit words sharing one read bus. Port 0 is fetch
// (word loads only), port 1 is load/store. One access is in flight at a time.
// Optional feature macro: MEM_PORT_ARBITER_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses fault (no write, err=1)
//   undefined -> misaligned half/word addresses are force-aligned
module mem_port_arbiter #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic [31:0]      p0_addr,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [31:0]      p0_rdata,
  output logic             p0_rsp_err,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic [31:0]      p1_addr,
  input  logic             p1_we,
  input  logic [1:0]       p1_size,
  input  logic [31:0]      p1_wdata,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [31:0]      p1_rdata,
  output logic             p1_rsp_err,
  output logic [WORDS-1:0] mem_word_sel,
  output logic [3:0]       mem_write_enable,
  output logic [31:0]      mem_write_value,
  input  logic [31:0]      mem_read_value
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]      off;
  logic [31:0]      idx;
  logic [1:0]       lane;
  logic             fault;
  logic [WORDS-1:0] sel_dec;
  logic [3:0]       mask_dec;
  logic [31:0]      wval_dec;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_data;
  logic             grant0;
  logic             grant1;

  // Decode the latched request: word index, byte lane, fault, masks, load data
  always_comb begin
    off   = addr_q - BASE_ADDR;
    idx   = off >> 2;
    fault = (addr_q < BASE_ADDR) || (idx >= WORDS) || (size_q == SZ_RSVD);
`ifdef MEM_PORT_ARBITER_MISALIGN_TRAP_EN
    lane = addr_q[1:0];
    if (((size_q == SZ_HALF) && addr_q[0]) ||
        ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))) begin
      fault = 1'b1;
    end
`else
    case (size_q)
      SZ_HALF: lane = {addr_q[1], 1'b0};
      SZ_WORD: lane = 2'b00;
      default: lane = addr_q[1:0];
    endcase
`endif
    sel_dec = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      sel_dec[i] = (idx == 32'(i));
    end
    rd_shift = mem_read_value >> {lane, 3'b000};
    case (size_q)
      SZ_BYTE: begin
        mask_dec = 4'b0001 << lane;
        wval_dec = {4{wdata_q[7:0]}};
        rd_data  = rd_shift & 32'h0000_00FF;
      end
      SZ_HALF: begin
        mask_dec = 4'b0011 << lane;
        wval_dec = {2{wdata_q[15:0]}};
        rd_data  = rd_shift & 32'h0000_FFFF;
      end
      default: begin
        mask_dec = 4'b1111;
        wval_dec = wdata_q;
        rd_data  = rd_shift;
      end
    endcase
  end

  // Round-robin winner: a lone requester wins, a tie goes to the port not granted last
  assign grant0 = p0_req_valid && (!p1_req_valid || last_q);
  assign grant1 = p1_req_valid && (!p0_req_valid || !last_q);

  // Next-state and combinational outputs of the IDLE -> ACCESS -> RESP sequencer
  always_comb begin
    state_d          = state_q;
    port_d           = port_q;
    last_d           = last_q;
    addr_d           = addr_q;
    we_d             = we_q;
    size_d           = size_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    p0_req_ready     = 1'b0;
    p1_req_ready     = 1'b0;
    mem_word_sel     = '0;
    mem_write_enable = 4'b0000;
    mem_write_value  = 32'h0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (grant0) begin
            p0_req_ready = 1'b1;
            port_d       = 1'b0;
            last_d       = 1'b0;
            addr_d       = p0_addr;
            we_d         = 1'b0;
            size_d       = SZ_WORD;
            wdata_d      = 32'h0;
            state_d      = S_ACCESS;
          end else if (grant1) begin
            p1_req_ready = 1'b1;
            port_d       = 1'b1;
            last_d       = 1'b1;
            addr_d       = p1_addr;
            we_d         = p1_we;
            size_d       = p1_size;
            wdata_d      = p1_wdata;
            state_d      = S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!fault) begin
            mem_word_sel = sel_dec;
            if (we_q) begin
              mem_write_enable = mask_dec;
              mem_write_value  = wval_dec;
            end
          end
          rdata_d = fault ? 32'h0 : rd_data;
          err_d   = fault;
          state_d = S_RESP;
        end
        S_RESP: begin
          if (port_q ? p1_rsp_ready : p0_rsp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and request/response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign p0_rsp_valid = (state_q == S_RESP) && !port_q;
  assign p1_rsp_valid = (state_q == S_RESP) && port_q;
  assign p0_rdata     = port_q ? 32'h0 : rdata_q;
  assign p1_rdata     = port_q ? rdata_q : 32'h0;
  assign p0_rsp_err   = !port_q && err_q;
  assign p1_rsp_err   = port_q && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, lane decode, faults and
// reset for mem_port_arbiter, with a small behavioural memory bank on the bus.
module tb_mem_port_arbiter;

  localparam int unsigned WORDS = 64;

`ifdef MEM_PORT_ARBITER_MISALIGN_TRAP_EN
  localparam logic [31:0] WORD4_AFTER_HALF = 32'hABAD_BEEF;
`else
  localparam logic [31:0] WORD4_AFTER_HALF = 32'hABAD_1234;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [31:0]      p0_addr, p0_rdata;
  logic             p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [1:0]       p1_size;
  logic [31:0]      p1_addr, p1_wdata, p1_rdata;
  logic [WORDS-1:0] mem_word_sel;
  logic [3:0]       mem_write_enable;
  logic [31:0]      mem_write_value, mem_read_value;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [WORDS] = '{default: 32'h0};

  mem_port_arbiter #(.WORDS(WORDS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rdata(p0_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
    .p1_we(p1_we), .p1_size(p1_size), .p1_wdata(p1_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rdata(p1_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_word_sel(mem_word_sel), .mem_write_enable(mem_write_enable),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value)
  );

  always #5 clk = ~clk;

  // Memory bank: byte-lane writes on the clock edge, selected word drives the read bus
  always @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (mem_word_sel[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_write_enable[b]) mem[i][8*b +: 8] <= mem_write_value[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    mem_read_value = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      if (mem_word_sel[i]) mem_read_value = mem_read_value | mem[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // One complete request on a single port; returns ACCESS-cycle bus values and response
  task automatic access(input bit port, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic [63:0] sel, output logic [3:0] mask,
                        output logic [31:0] wval, output logic [31:0] rdata,
                        output logic err, output int lat);
    bit granted = 1'b0;
    bit got     = 1'b0;
    sel = '0; mask = '0; wval = '0; rdata = '0; err = 1'b0; lat = -1;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    if (port) begin
      p1_req_valid = 1'b1; p1_addr = addr; p1_we = we; p1_size = size; p1_wdata = wdata;
    end else begin
      p0_req_valid = 1'b1; p0_addr = addr;
    end
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      if (port ? p1_req_ready : p0_req_ready) granted = 1'b1;
      @(posedge clk); #1;
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    if (!granted) begin
      check("grant_timeout", 64'd0, 64'd1);
      return;
    end
    #1;
    sel  = 64'(mem_word_sel);
    mask = mem_write_enable;
    wval = mem_write_value;
    lat  = 1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (port ? p1_rsp_valid : p0_rsp_valid) begin
        got   = 1'b1;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_rsp_err : p0_rsp_err;
      end
    end
    if (!got) check("rsp_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] sel;
    logic [3:0]  mask;
    logic [31:0] wval, rdata;
    logic        err;
    int          lat;
    bit          who [4];
    bit          seen;

    reset = 1'b1;
    p0_req_valid = 1'b1; p0_addr = 32'h0; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_addr = 32'h0; p1_we = 1'b0; p1_size = 2'd2;
    p1_wdata = 32'h0; p1_rsp_ready = 1'b1;

    // Reset held two cycles with both ports requesting
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_p0_ready", 64'(p0_req_ready), 64'd0);
      check("rst_p1_ready", 64'(p1_req_ready), 64'd0);
      check("rst_sel", 64'(mem_word_sel), 64'd0);
      check("rst_we", 64'(mem_write_enable), 64'd0);
      check("rst_rsp", 64'({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}), 64'd0);
      check("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'd0);
    end
    reset = 1'b0;
    #1;
    check("first_grant_p0", 64'(p0_req_ready), 64'd1);
    check("first_grant_not_p1", 64'(p1_req_ready), 64'd0);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    @(posedge clk); #1;
    check("withdrawn_no_access", 64'(mem_word_sel), 64'd0);

    // Word store then fetch of the same word
    access(1'b1, 32'h10, 1'b1, 2'd2, 32'hDEAD_BEEF, sel, mask, wval, rdata, err, lat);
    check("sw_sel", sel, 64'h10);
    check("sw_mask", 64'(mask), 64'hF);
    check("sw_wval", 64'(wval), 64'hDEAD_BEEF);
    check("sw_lat", 64'(lat), 64'd2);
    check("sw_err", 64'(err), 64'd0);
    access(1'b0, 32'h10, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
    check("fetch_rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("fetch_mask", 64'(mask), 64'h0);
    check("fetch_err", 64'(err), 64'd0);

    // Byte store into lane 3 and narrow loads
    access(1'b1, 32'h13, 1'b1, 2'd0, 32'h0000_00AB, sel, mask, wval, rdata, err, lat);
    check("sb_sel", sel, 64'h10);
    check("sb_mask", 64'(mask), 64'h8);
    check("sb_wval", 64'(wval), 64'hABAB_ABAB);
    access(1'b1, 32'h13, 1'b0, 2'd0, 32'h0, sel, mask, wval, rdata, err, lat);
    check("lb3_rdata", 64'(rdata), 64'h0000_00AB);
    check("lb3_mask", 64'(mask), 64'h0);
    access(1'b1, 32'h11, 1'b0, 2'd0, 32'h0, sel, mask, wval, rdata, err, lat);
    check("lb1_rdata", 64'(rdata), 64'h0000_00BE);
    access(1'b1, 32'h12, 1'b0, 2'd1, 32'h0, sel, mask, wval, rdata, err, lat);
    check("lh2_rdata", 64'(rdata), 64'h0000_ABAD);
    access(1'b1, 32'h10, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
    check("lw_rdata", 64'(rdata), 64'hABAD_BEEF);

    // Both ports requesting continuously: grants alternate
    p0_addr = 32'h10; p1_addr = 32'h10; p1_we = 1'b0; p1_size = 2'd2;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      who[k] = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        #1;
        if (p0_req_ready || p1_req_ready) begin
          seen = 1'b1;
          who[k] = p1_req_ready;
          check("ready_onehot", 64'(p0_req_ready & p1_req_ready), 64'd0);
        end
        @(posedge clk); #1;
      end
      if (!seen) check("rr_grant_timeout", 64'd0, 64'd1);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    check("rr_order", 64'({who[0], who[1], who[2], who[3]}), 64'b0101);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Response held with rsp_ready low: stable response and no new grant
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    #1;
    check("hold_grant_p0", 64'({p0_req_ready, p1_req_ready}), 64'b10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_rsp_valid", 64'({p0_rsp_valid, p1_rsp_valid}), 64'b10);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("hold_still_valid", 64'({p0_rsp_valid, p1_rsp_valid}), 64'b10);
      check("hold_rdata", 64'(p0_rdata), 64'hABAD_BEEF);
      check("hold_no_grant", 64'({p0_req_ready, p1_req_ready}), 64'b00);
    end
    p0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_next_p1", 64'({p0_req_ready, p1_req_ready}), 64'b01);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    p1_rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Faults: out of range, reserved size, out-of-range store
    access(1'b1, 32'h100, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
    check("oob_sel", sel, 64'h0);
    check("oob_err", 64'(err), 64'd1);
    check("oob_rdata", 64'(rdata), 64'h0);
    access(1'b1, 32'h10, 1'b0, 2'd3, 32'h0, sel, mask, wval, rdata, err, lat);
    check("rsvd_sel", sel, 64'h0);
    check("rsvd_err", 64'(err), 64'd1);
    check("rsvd_rdata", 64'(rdata), 64'h0);
    access(1'b1, 32'h104, 1'b1, 2'd2, 32'h1111_1111, sel, mask, wval, rdata, err, lat);
    check("oob_st_mask", 64'(mask), 64'h0);
    check("oob_st_err", 64'(err), 64'd1);

    // Misaligned half store
    access(1'b1, 32'h11, 1'b1, 2'd1, 32'h0000_1234, sel, mask, wval, rdata, err, lat);
`ifdef MEM_PORT_ARBITER_MISALIGN_TRAP_EN
    check("sh_mis_err", 64'(err), 64'd1);
    check("sh_mis_mask", 64'(mask), 64'h0);
    check("sh_mis_sel", sel, 64'h0);
`else
    check("sh_mis_err", 64'(err), 64'd0);
    check("sh_mis_mask", 64'(mask), 64'h3);
    check("sh_mis_sel", sel, 64'h10);
    check("sh_mis_wval", 64'(wval), 64'h1234_1234);
`endif
    access(1'b1, 32'h10, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
    check("after_sh_word", 64'(rdata), 64'(WORD4_AFTER_HALF));
    access(1'b1, 32'h12, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
`ifdef MEM_PORT_ARBITER_MISALIGN_TRAP_EN
    check("lw_mis_err", 64'(err), 64'd1);
    check("lw_mis_rdata", 64'(rdata), 64'h0);
`else
    check("lw_mis_err", 64'(err), 64'd0);
    check("lw_mis_rdata", 64'(rdata), 64'(WORD4_AFTER_HALF));
`endif

    // Reset during RESP drops the response; next request served normally
    p1_rsp_ready = 1'b0;
    p1_addr = 32'h10; p1_we = 1'b0; p1_size = 2'd2;
    p1_req_valid = 1'b1;
    #1;
    check("rr_rst_grant", 64'(p1_req_ready), 64'd1);
    @(posedge clk); #1;
    p1_req_valid = 1'b0;
    @(posedge clk); #1;
    check("rr_rst_in_resp", 64'(p1_rsp_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_resp_dropped", 64'(p1_rsp_valid), 64'd0);
    check("rst_resp_sel", 64'(mem_word_sel), 64'd0);
    reset = 1'b0;
    access(1'b0, 32'h10, 1'b0, 2'd2, 32'h0, sel, mask, wval, rdata, err, lat);
    check("post_rst_rdata", 64'(rdata), 64'(WORD4_AFTER_HALF));
    check("post_rst_lat", 64'(lat), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
